// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the memory arbiter and the cache blocks that talk to it.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package memory_arbiter_pkg;

  // Words moved per block transfer (power of two, 2..16).
  localparam int WORDS_PER_BLOCK = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } arbState_t;

  // Which cache owns the memory port.
  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } owner_t;

endpackage

// File: rtl/block_word_counter.sv
// Word index within a block transfer, with wrap and a last-word flag.
// Latency: index updates on the clock edge after clear/advance.
// Backpressure: holds its value while advance is low (memory stalled).
// Ports: clk, reset (async active-low), clear (restart at word 0),
//        advance (current word completed), index (current word), last (index is final word).
module block_word_counter #(
  parameter  int WORDS = 4,
  localparam int IDX_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [IDX_W-1:0] index,
  output logic             last
);

  assign last = (index == IDX_W'(WORDS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index <= '0;
    end else if (clear) begin
      index <= '0;
    end else if (advance) begin
      index <= last ? '0 : index + 1'b1;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter giving the I-cache or D-cache ownership of one memory port for a block.
// Latency: WORDS_PER_BLOCK+2 cycles from grant to Done with memReady held high.
// Backpressure: memReady low freezes the current word; memory outputs stay stable, no timeout.
// Ports: iReq/iAddr/iGrant/iDone (I-cache refill), dReq/dWrite/dAddr/dWData/dGrant/dDone
//        (D-cache refill or write-back), wordIndex/rData/rValid (shared word return),
//        memReq/memWrite/memAddr/memWData/memReady/memRData (memory word interface).
module memory_arbiter #(
  parameter  int WORDS_PER_BLOCK = memory_arbiter_pkg::WORDS_PER_BLOCK,
  parameter  int ADDR_WIDTH      = 32,
  parameter  int DATA_WIDTH      = 32,
  localparam int IDX_W           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iReq,
  input  logic [ADDR_WIDTH-1:0] iAddr,
  output logic                  iGrant,
  input  logic                  dReq,
  input  logic                  dWrite,
  input  logic [ADDR_WIDTH-1:0] dAddr,
  input  logic [DATA_WIDTH-1:0] dWData,
  output logic                  dGrant,
  output logic [IDX_W-1:0]      wordIndex,
  output logic [DATA_WIDTH-1:0] rData,
  output logic                  rValid,
  output logic                  iDone,
  output logic                  dDone,
  output logic                  memReq,
  output logic                  memWrite,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memWData,
  input  logic                  memReady,
  input  logic [DATA_WIDTH-1:0] memRData
);

  import memory_arbiter_pkg::*;

  // Byte offset bits inside a block: word index plus the 4-byte word offset.
  localparam int OFFSET_BITS = IDX_W + 2;
  localparam logic [ADDR_WIDTH-1:0] BASE_MASK =
    ~((ADDR_WIDTH'(1) << OFFSET_BITS) - ADDR_WIDTH'(1));

  arbState_t             state, nextState;
  owner_t                owner, nextOwner, lastOwner;
  logic [ADDR_WIDTH-1:0] base;
  logic                  dirWrite;
  logic                  wordDone;
  logic                  lastWord;

  block_word_counter #(.WORDS(WORDS_PER_BLOCK)) uWordCounter (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == GRANT),
    .advance (wordDone),
    .index   (wordIndex),
    .last    (lastWord)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    nextOwner = owner;
    iGrant    = 1'b0;
    dGrant    = 1'b0;
    iDone     = 1'b0;
    dDone     = 1'b0;
    memReq    = 1'b0;
    memWrite  = 1'b0;
    memAddr   = '0;
    memWData  = '0;
    wordDone  = 1'b0;
    rValid    = 1'b0;
    rData     = '0;

    case (state)
      IDLE: begin
        // Requests are only looked at here; a tie goes to whoever was not served last.
        if (iReq && dReq) begin
          nextOwner = (lastOwner == INSTR) ? DATA : INSTR;
          nextState = GRANT;
        end else if (iReq) begin
          nextOwner = INSTR;
          nextState = GRANT;
        end else if (dReq) begin
          nextOwner = DATA;
          nextState = GRANT;
        end
      end
      GRANT: nextState = XFER;
      XFER: begin
        if (memReady && lastWord) begin
          nextState = DONE;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase

    if (state != IDLE) begin
      iGrant = (owner == INSTR);
      dGrant = (owner == DATA);
    end

    if (state == DONE) begin
      iDone = (owner == INSTR);
      dDone = (owner == DATA);
    end

    // Address and write data are pure functions of latched state and wordIndex,
    // so they cannot move while memReady is low.
    if (state == XFER) begin
      memReq   = 1'b1;
      memWrite = dirWrite;
      memAddr  = base + (ADDR_WIDTH'(wordIndex) << 2);
      memWData = dirWrite ? dWData : '0;
      wordDone = memReady;
      rValid   = memReady && !dirWrite;
      rData    = (memReady && !dirWrite) ? memRData : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner     <= INSTR;
      lastOwner <= INSTR;
      base      <= '0;
      dirWrite  <= 1'b0;
    end else begin
      owner <= nextOwner;
      if (state == GRANT) begin
        // I-cache traffic is always a refill.
        base     <= ((owner == DATA) ? dAddr : iAddr) & BASE_MASK;
        dirWrite <= (owner == DATA) && dWrite;
      end
      if (state == DONE) begin
        lastOwner <= owner;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: scoreboard of expected memory words plus per-cycle invariants.
// Latency: n/a.
// Backpressure: memReady is driven per test, including a multi-cycle stall.
module tb_memory_arbiter;

  localparam logic [31:0] MAGIC  = 32'h5A5A_0000;
  localparam logic [31:0] WMAGIC = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        iReq;
  logic [31:0] iAddr;
  logic        iGrant;
  logic        dReq;
  logic        dWrite;
  logic [31:0] dAddr;
  logic [31:0] dWData;
  logic        dGrant;
  logic [1:0]  wordIndex;
  logic [31:0] rData;
  logic        rValid;
  logic        iDone;
  logic        dDone;
  logic        memReq;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic        memReady;
  logic [31:0] memRData;

  always #5 clk = ~clk;

  // Memory returns an address-derived word; the D-cache supplies a word-index-derived write word.
  assign memRData = memAddr ^ MAGIC;
  assign dWData   = WMAGIC | {30'b0, wordIndex};

  memory_arbiter #(.WORDS_PER_BLOCK(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .iReq(iReq), .iAddr(iAddr), .iGrant(iGrant),
    .dReq(dReq), .dWrite(dWrite), .dAddr(dAddr), .dWData(dWData), .dGrant(dGrant),
    .wordIndex(wordIndex), .rData(rData), .rValid(rValid),
    .iDone(iDone), .dDone(dDone),
    .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr), .memWData(memWData),
    .memReady(memReady), .memRData(memRData)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        write;
  } expWord_t;

  expWord_t sb[$];
  int       grantLog[$];
  int       compared   = 0;
  int       mismatched = 0;
  int       rValidCnt  = 0;
  int       iDoneCnt   = 0;
  int       dDoneCnt   = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pushBlock(input logic [31:0] baseAddr, input logic isWrite);
    expWord_t e;
    for (int k = 0; k < 4; k++) begin
      e.addr  = baseAddr + 32'(4 * k);
      e.write = isWrite;
      e.data  = isWrite ? (WMAGIC | 32'(k)) : (e.addr ^ MAGIC);
      sb.push_back(e);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_iGrant"},    64'(iGrant),    64'h0);
    checkVal({tag, "_dGrant"},    64'(dGrant),    64'h0);
    checkVal({tag, "_memReq"},    64'(memReq),    64'h0);
    checkVal({tag, "_memWrite"},  64'(memWrite),  64'h0);
    checkVal({tag, "_rValid"},    64'(rValid),    64'h0);
    checkVal({tag, "_iDone"},     64'(iDone),     64'h0);
    checkVal({tag, "_dDone"},     64'(dDone),     64'h0);
    checkVal({tag, "_wordIndex"}, 64'(wordIndex), 64'h0);
    checkVal({tag, "_memAddr"},   64'(memAddr),   64'h0);
    checkVal({tag, "_memWData"},  64'(memWData),  64'h0);
    checkVal({tag, "_rData"},     64'(rData),     64'h0);
  endtask

  task automatic tickIn();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDones(input int n, input int bound);
    int start;
    logic ok;
    start = iDoneCnt + dDoneCnt;
    ok    = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      #1;
      if (iDoneCnt + dDoneCnt >= start + n) begin
        ok = 1'b1;
        break;
      end
    end
    checkVal("doneTimeout", 64'(ok), 64'h1);
  endtask

  // Per-cycle monitor: scoreboard pops on completed words, grant exclusivity, Done pulse width.
  logic     prevIDone  = 1'b0;
  logic     prevDDone  = 1'b0;
  logic     prevIGrant = 1'b0;
  logic     prevDGrant = 1'b0;
  expWord_t mon;

  always @(negedge clk) begin
    checkVal("grantMutex", 64'(iGrant & dGrant), 64'h0);
    if (memReq && memReady) begin
      if (sb.size() == 0) begin
        checkVal("sbUnderflow", 64'(sb.size()), 64'h1);
      end else begin
        mon = sb.pop_front();
        checkVal("memAddr",  64'(memAddr),  64'(mon.addr));
        checkVal("memWrite", 64'(memWrite), 64'(mon.write));
        checkVal("rValid",   64'(rValid),   64'(!mon.write));
        if (mon.write) checkVal("memWData", 64'(memWData), 64'(mon.data));
        else           checkVal("rData",    64'(rData),    64'(mon.data));
      end
    end else begin
      checkVal("rValidIdle", 64'(rValid), 64'h0);
    end
    if (rValid) rValidCnt++;
    if (iDone) begin
      checkVal("iDoneWidth", 64'(prevIDone), 64'h0);
      checkVal("iDoneGrant", 64'(iGrant),    64'h1);
      iDoneCnt++;
    end
    if (dDone) begin
      checkVal("dDoneWidth", 64'(prevDDone), 64'h0);
      checkVal("dDoneGrant", 64'(dGrant),    64'h1);
      dDoneCnt++;
    end
    if (iGrant && !prevIGrant) grantLog.push_back(0);
    if (dGrant && !prevDGrant) grantLog.push_back(1);
    prevIDone  = iDone;
    prevDDone  = dDone;
    prevIGrant = iGrant;
    prevDGrant = dGrant;
  end

  initial begin
    int   g;
    int   d;
    int   rv0;
    int   stall;
    int   base0;
    logic hit;

    reset = 1'b0; iReq = 1'b0; dReq = 1'b0; dWrite = 1'b0;
    iAddr = '0; dAddr = '0; memReady = 1'b0;
    #1;
    checkAllZero("inReset");
    repeat (3) tickIn();
    reset = 1'b1;
    tickIn();
    checkAllZero("afterReset");

    // I-cache refill from an unaligned miss address, memory always ready.
    pushBlock(32'h100, 1'b0);
    memReady = 1'b1;
    iAddr    = 32'h104;
    iReq     = 1'b1;
    g = -1; d = -1; rv0 = rValidCnt;
    for (int c = 1; c <= 30 && d < 0; c++) begin
      @(negedge clk);
      #1;
      if (iGrant && g < 0) g = c;
      if (iDone) d = c;
    end
    checkVal("t1DoneSeen", 64'(d >= 0), 64'h1);
    checkVal("t1Latency",  64'(d - g + 1), 64'h6);
    tickIn();
    iReq = 1'b0;
    checkVal("t1rValidCnt", 64'(rValidCnt - rv0), 64'h4);
    checkVal("t1sbEmpty",   64'(sb.size()), 64'h0);

    // Simultaneous requests from reset: data first, then alternation while both stay high.
    reset = 1'b0;
    tickIn();
    reset = 1'b1;
    tickIn();
    grantLog.delete();
    pushBlock(32'h300, 1'b0);
    pushBlock(32'h400, 1'b0);
    pushBlock(32'h300, 1'b0);
    dWrite = 1'b0; dAddr = 32'h300; iAddr = 32'h400;
    iReq = 1'b1; dReq = 1'b1;
    waitDones(3, 60);
    tickIn();
    iReq = 1'b0; dReq = 1'b0;
    checkVal("t2GrantCount", 64'(grantLog.size()), 64'h3);
    if (grantLog.size() >= 3) begin
      checkVal("t2First",  64'(grantLog[0]), 64'h1);
      checkVal("t2Second", 64'(grantLog[1]), 64'h0);
      checkVal("t2Third",  64'(grantLog[2]), 64'h1);
    end

    // D-cache write-back with a three-cycle stall on word 2.
    pushBlock(32'h200, 1'b1);
    dWrite = 1'b1; dAddr = 32'h200; dReq = 1'b1;
    stall = 0; hit = 1'b0; rv0 = rValidCnt;
    for (int c = 0; c < 40; c++) begin
      if (memReq && wordIndex == 2'd2 && stall < 3) begin
        memReady = 1'b0;
        stall++;
      end else begin
        memReady = 1'b1;
      end
      @(negedge clk);
      #1;
      if (!memReady && memReq) begin
        checkVal("t3StallAddr",   64'(memAddr),  64'h208);
        checkVal("t3StallWData",  64'(memWData), 64'(WMAGIC | 32'h2));
        checkVal("t3StallWrite",  64'(memWrite), 64'h1);
        checkVal("t3StallRValid", 64'(rValid),   64'h0);
      end
      if (dDone) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    memReady = 1'b1;
    checkVal("t3Done",      64'(hit),   64'h1);
    checkVal("t3Stalls",    64'(stall), 64'h3);
    checkVal("t3NoRValid",  64'(rValidCnt - rv0), 64'h0);
    tickIn();
    dReq = 1'b0; dWrite = 1'b0;

    // Reset during word 1 of an I-refill abandons the block; held request is granted again.
    pushBlock(32'h500, 1'b0);
    iAddr = 32'h500; iReq = 1'b1;
    base0 = iDoneCnt; hit = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tickIn();
      if (memReq && wordIndex == 2'd1) begin
        hit = 1'b1;
        break;
      end
    end
    checkVal("t4ReachedWord1", 64'(hit), 64'h1);
    #1;
    reset = 1'b0;
    #1;
    checkAllZero("t4Reset");
    checkVal("t4Abandoned", 64'(sb.size()), 64'h3);
    sb.delete();
    pushBlock(32'h500, 1'b0);
    repeat (2) tickIn();
    checkVal("t4NoDoneInReset", 64'(iDoneCnt - base0), 64'h0);
    reset = 1'b1;
    waitDones(1, 30);
    tickIn();
    iReq = 1'b0;
    checkVal("t4RegrantDone", 64'(iDoneCnt - base0), 64'h1);

    // Data request dropped mid-transfer still completes its whole block.
    pushBlock(32'h610, 1'b0);
    dAddr = 32'h61C; dWrite = 1'b0; dReq = 1'b1;
    base0 = dDoneCnt; hit = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tickIn();
      if (memReq) begin
        hit = 1'b1;
        break;
      end
    end
    checkVal("t5InXfer", 64'(hit), 64'h1);
    dReq = 1'b0;
    repeat (15) tickIn();
    checkVal("t5DoneOnce", 64'(dDoneCnt - base0), 64'h1);
    checkVal("t5sbEmpty",  64'(sb.size()), 64'h0);
    checkVal("t5Idle",     64'(dGrant), 64'h0);

    checkVal("sbFinal", 64'(sb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter WORDS_PER_BLOCK, default 4, meaning words moved per block transfer; power of two, 2..16.
REQ-002 Parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-003 Parameter DATA_WIDTH, default 32, meaning word width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 iReq  input  1  instruction-cache block-read request, held until iDone.
REQ-007 iAddr  input  ADDR_WIDTH  instruction-cache miss address.
REQ-008 iGrant  output  1  transfer owned by instruction cache.
REQ-009 dReq  input  1  data-cache block request, held until dDone.
REQ-010 dWrite  input  1  data-cache request is a write-back (1) or a refill (0).
REQ-011 dAddr  input  ADDR_WIDTH  data-cache block address.
REQ-012 dWData  input  DATA_WIDTH  write-back word selected by wordIndex.
REQ-013 dGrant  output  1  transfer owned by data cache.
REQ-014 wordIndex  output  log2(WORDS_PER_BLOCK)  index of the current word in the block.
REQ-015 rData  output  DATA_WIDTH  read word broadcast to both caches.
REQ-016 rValid  output  1  rData valid for wordIndex this cycle (owner only).
REQ-017 iDone / dDone  output  1 each  one-cycle pulse when the owner's block completes.
REQ-018 memReq, memWrite  output  1 each  memory word request and its direction.
REQ-019 memAddr, memWData  output  ADDR_WIDTH, DATA_WIDTH  memory word address and write data.
REQ-020 memReady, memRData  input  1, DATA_WIDTH  memory accepted/returned word this cycle; read data.

Function
REQ-021 States IDLE, GRANT, XFER, DONE; exactly one state active at a time.
REQ-022 IDLE: with no requests, stay in IDLE; with exactly one request, grant that requester; with both requesting, grant the requester not served last (round-robin bit lastOwner, reset value = instruction, so the data cache wins the first tie).
REQ-023 GRANT (one cycle): latch block base = owner address with low log2(WORDS_PER_BLOCK)+2 bits cleared; latch direction; wordIndex=0; go to XFER.
REQ-024 XFER: memReq=1, memAddr=base+4*wordIndex, memWrite=latched direction, memWData=dWData; requests are sampled only in IDLE.
REQ-025 XFER with memReady=1: the word completes; on reads, rData=memRData and rValid=1 in the same cycle; wordIndex increments.
REQ-026 XFER with memReady=0: hold all memory outputs stable, no rValid; no timeout.
REQ-027 When the last word completes, wordIndex wraps to 0 and the next state is DONE.
REQ-028 DONE (one cycle): pulse the owner's Done, keep its Grant high, update lastOwner, return to IDLE; a requester still high re-enters arbitration on the next cycle.
REQ-029 iGrant and dGrant are never high together; each is high from GRANT through DONE only.
REQ-030 Instruction-cache requests are always reads; iAddr changes while not granted are ignored.
REQ-031 A request dropped mid-transfer does not abort the transfer; the block completes.
REQ-032 Minimum block latency: WORDS_PER_BLOCK+2 cycles from grant to Done with memReady held at 1.

Reset
REQ-033 reset low asynchronously forces: state=IDLE; iGrant, dGrant, memReq, memWrite, rValid, iDone, dDone all 0; wordIndex=0; memAddr, memWData, rData=0; lastOwner=instruction.
REQ-034 Reset asserted mid-XFER abandons the block with no Done pulse; after release, arbitration restarts from IDLE.

Structure
REQ-035 The shared include file holds WORDS_PER_BLOCK, state encodings, and the owner encoding (INSTR=0, DATA=1), shared with the cache blocks.
REQ-036 The word counter with wrap and last-word flag is one sub-module, block_word_counter; arbitration and the FSM stay in memory_arbiter.

Verification
REQ-037 Test: iReq=1 only, iAddr=0x104, memReady=1. Required response: memAddr 0x100,0x104,0x108,0x10C; rValid 4 cycles; iDone at cycle 6.
REQ-038 Test: iReq and dReq rise together after reset. Required response: dGrant first, then iGrant; repeat the tie and grants alternate.
REQ-039 Test: dReq=1, dWrite=1, dAddr=0x200, memReady low for 3 cycles on word 2. Required response: memAddr=0x208 and memWData held; rValid never asserts.
REQ-040 Test: reset low during word 1 of an I-refill. Required response: all outputs 0 immediately; no iDone; iReq held high is re-granted after release.
REQ-041 Test: dReq dropped during XFER. Required response: all 4 words are still transferred and dDone pulses once.
REQ-042 Test: check every cycle. Required response: iGrant&dGrant==0, and each Done pulse is exactly 1 cycle.
